// File: rtl/spiflash_ctrl.sv
// SPI NOR flash host sequencer: one byte read/write per 49-bit frame
// (32-bit address, 8-bit command, 8-bit data, 1 commit bit), SPI mode 0.
module spiflash_ctrl #(
    parameter int DIV = 2,
    parameter int GAP = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic        ReqWrite,
    input  logic [31:0] ReqAdr,
    input  logic [7:0]  ReqWData,
    output logic        RspValid,
    output logic [7:0]  RspRData,
    output logic        Busy,
    output logic        SCLK,
    output logic        CS,
    output logic        MOSI,
    input  logic        MISO
);
    // Request handshake: a request transfers on a rising clk edge where
    // ReqValid and ReqReady are both high; ReqValid while not ready is dropped.
    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAPW} state_t;

    state_t      state, state_nxt;
    logic [15:0] cnt, cnt_nxt;
    logic [6:0]  half, half_nxt;
    logic [48:0] sh, sh_nxt;
    logic [7:0]  rx, rx_nxt;
    logic        wr, wr_nxt;
    logic        sclk_nxt, cs_nxt, ready_nxt, rsp_v_nxt;
    logic [7:0]  rsp_d_nxt;

    // MOSI is the head of the frame shift register, so it moves only when
    // the register shifts, which happens on falling-edge cycles.
    assign MOSI = sh[48];
    assign Busy = (state != IDLE);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 16'd1;
        half_nxt  = half;
        sh_nxt    = sh;
        rx_nxt    = rx;
        wr_nxt    = wr;
        sclk_nxt  = SCLK;
        rsp_v_nxt = 1'b0;
        rsp_d_nxt = RspRData;
        case (state)
            IDLE: begin
                cnt_nxt = 16'd0;
                if (ReqValid && ReqReady) begin
                    state_nxt = SETUP;
                    wr_nxt    = ReqWrite;
                    sh_nxt    = {ReqAdr, (ReqWrite ? 8'h02 : 8'h01),
                                 (ReqWrite ? ReqWData : 8'h00), 1'b0};
                    rx_nxt    = 8'h00;
                end
            end
            SETUP: begin
                if (cnt == 16'(DIV - 1)) begin
                    state_nxt = SHIFT;
                    cnt_nxt   = 16'd0;
                    half_nxt  = 7'd0;
                    sclk_nxt  = 1'b1;
                end
            end
            SHIFT: begin
                // Even half-periods have SCLK high, odd ones low; the last
                // (97th) low half keeps SCLK parked before HOLD.
                if (cnt == 16'(DIV - 1)) begin
                    cnt_nxt = 16'd0;
                    if (half == 7'd97) begin
                        state_nxt = HOLD;
                        sclk_nxt  = 1'b0;
                    end else begin
                        half_nxt = half + 7'd1;
                        sclk_nxt = ~SCLK;
                        if (!half[0])
                            sh_nxt = {sh[47:0], 1'b0};
                        else if (half >= 7'd79 && half <= 7'd93)
                            rx_nxt = {rx[6:0], MISO};
                    end
                end
            end
            HOLD: begin
                if (cnt == 16'(DIV - 1)) begin
                    cnt_nxt   = 16'd0;
                    rsp_v_nxt = 1'b1;
                    rsp_d_nxt = wr ? 8'h00 : rx;
                    state_nxt = (GAP > 1) ? GAPW : IDLE;
                end
            end
            GAPW: begin
                // The IDLE cycle before the next accept is the last gap cycle.
                if (cnt == 16'(GAP - 2))
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        cs_nxt    = !(state_nxt == SETUP || state_nxt == SHIFT || state_nxt == HOLD);
        ready_nxt = (state_nxt == IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= 16'd0;
            half     <= 7'd0;
            sh       <= 49'd0;
            rx       <= 8'h00;
            wr       <= 1'b0;
            SCLK     <= 1'b0;
            CS       <= 1'b1;
            ReqReady <= 1'b0;
            RspValid <= 1'b0;
            RspRData <= 8'h00;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            half     <= half_nxt;
            sh       <= sh_nxt;
            rx       <= rx_nxt;
            wr       <= wr_nxt;
            SCLK     <= sclk_nxt;
            CS       <= cs_nxt;
            ReqReady <= ready_nxt;
            RspValid <= rsp_v_nxt;
            RspRData <= rsp_d_nxt;
        end
    end
endmodule

// File: tb/tb_spiflash_ctrl.sv
// Directed bench for spiflash_ctrl: a DIV=2 and a DIV=1 controller, each
// talking to its own small behavioural byte-wide SPI flash.
module tb_spiflash_ctrl;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [1:0]  req_valid;
    logic        req_write;
    logic [31:0] req_adr;
    logic [7:0]  req_wdata;
    logic [1:0]  rdy, rspv, busy, sclk, cs, mosi;
    logic [7:0]  rdata [2];

    int n_cmp = 0;
    int n_bad = 0;

    for (genvar g = 0; g < 2; g++) begin : u
        logic        miso_l;
        int          rises;
        logic [48:0] cap;
        logic [7:0]  mem [256];
        logic [7:0]  rd_adr, rd_cmd;

        spiflash_ctrl #(.DIV(g == 0 ? 2 : 1), .GAP(4)) dut (
            .clk(clk), .reset(reset),
            .ReqValid(req_valid[g]), .ReqReady(rdy[g]),
            .ReqWrite(req_write), .ReqAdr(req_adr), .ReqWData(req_wdata),
            .RspValid(rspv[g]), .RspRData(rdata[g]), .Busy(busy[g]),
            .SCLK(sclk[g]), .CS(cs[g]), .MOSI(mosi[g]), .MISO(miso_l)
        );

        initial begin
            for (int k = 0; k < 256; k++) mem[k] = 8'h00;
            mem[8'h10] = 8'hA5;
            miso_l = 1'b0;
            rises  = 0;
            cap    = '0;
            rd_adr = 8'h00;
            rd_cmd = 8'h00;
        end

        // Flash model: bits 1-32 address, 33-40 command, 41-48 data, 49 commit.
        always @(negedge cs[g]) begin
            rises = 0;
            cap   = '0;
        end
        always @(posedge sclk[g]) if (!cs[g]) begin
            rises++;
            cap = {cap[47:0], mosi[g]};
            if (rises == 40) begin
                rd_cmd = cap[7:0];
                rd_adr = cap[15:8];
            end
            if (rises == 49 && cap[16:9] == 8'h02)
                mem[cap[24:17]] = cap[8:1];
        end
        always @(negedge sclk[g]) if (!cs[g])
            miso_l = (rises >= 40 && rises < 48 && rd_cmd == 8'h01) ?
                     mem[rd_adr][7 - (rises - 40)] : 1'b0;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present a request and return #1 after its accept edge.
    task automatic send(input int i, input logic w, input logic [31:0] a, input logic [7:0] d);
        int t = 0;
        @(negedge clk);
        req_write = w; req_adr = a; req_wdata = d; req_valid[i] = 1'b1;
        while (!rdy[i] && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("ready_seen", rdy[i], 1'b1);
        @(posedge clk);
        #1;
        check("cs_low_after_accept", cs[i], 1'b0);
    endtask

    // Count edges after accept until RspValid; also time the first SCLK rises.
    task automatic wait_rsp(input int i, output int rsp_at, output int rise1,
                            output int per, output logic [7:0] rd);
        logic prev = 1'b0;
        int n = 0;
        rsp_at = -1; rise1 = -1; per = -1; rd = 8'hxx;
        while (n < 1000) begin
            @(posedge clk);
            n++;
            #1;
            if (sclk[i] && !prev) begin
                if (rise1 < 0) rise1 = n;
                else if (per < 0) per = n - rise1;
            end
            prev = sclk[i];
            if (rspv[i]) begin
                rsp_at = n;
                rd = rdata[i];
                break;
            end
        end
    endtask

    initial begin
        int rsp_at, rise1, per, gap_hi, acc2, pulses;
        logic [7:0] rd;
        logic prev_rdy;

        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int rsp_at, rise1, per, gap_hi, acc2, pulses, n;
        logic [7:0] rd;
        logic prev_rdy;

        reset = 1'b1; req_valid = 2'b00; req_write = 1'b0; req_adr = '0; req_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cs", cs[0], 1'b1);
        check("rst_sclk", sclk[0], 1'b0);
        check("rst_mosi", mosi[0], 1'b0);
        check("rst_rspv", rspv[0], 1'b0);
        check("rst_rdata", rdata[0], 8'h00);
        check("rst_busy", busy[0], 1'b0);
        check("rst_ready", rdy[0], 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("ready_after_reset", rdy[0], 1'b1);

        // Write 0x10 <- 0xA5, DIV=2
        send(0, 1'b1, 32'h0000_0010, 8'hA5);
        req_valid[0] = 1'b0;
        wait_rsp(0, rsp_at, rise1, per, rd);
        check("wr_rsp_cycle", rsp_at, 200);
        check("wr_rdata", rd, 8'h00);
        check("wr_first_rise", rise1, 2);
        check("wr_sclk_period", per, 4);
        check("wr_rises", u[0].rises, 49);
        check("wr_frame", u[0].cap, {32'h0000_0010, 8'h02, 8'hA5, 1'b0});

        // Read 0x10
        send(0, 1'b0, 32'h0000_0010, 8'hFF);
        req_valid[0] = 1'b0;
        wait_rsp(0, rsp_at, rise1, per, rd);
        check("rd_rsp_cycle", rsp_at, 200);
        check("rd_rdata", rd, 8'hA5);
        check("rd_frame", u[0].cap, {32'h0000_0010, 8'h01, 8'h00, 1'b0});

        // Back-to-back with ReqValid held: write 0x20 <- 0x5A, then read 0x20
        send(0, 1'b1, 32'h0000_0020, 8'h5A);
        req_write = 1'b0; req_adr = 32'h0000_0020; req_wdata = 8'h00;
        n = 0; gap_hi = 0; acc2 = -1; prev_rdy = 1'b0; rsp_at = -1;
        while (n < 600) begin
            @(posedge clk);
            n++;
            if (prev_rdy) begin
                acc2 = n;
                break;
            end
            #1;
            if (rspv[0]) rsp_at = n;
            if (rsp_at > 0 && cs[0]) gap_hi++;
            prev_rdy = rdy[0];
        end
        #1;
        req_valid[0] = 1'b0;
        check("b2b_first_rsp", rsp_at, 200);
        check("b2b_cs_gap", gap_hi, 4);
        check("b2b_second_accept", acc2, 204);
        wait_rsp(0, rsp_at, rise1, per, rd);
        check("b2b_rd_rsp_cycle", rsp_at, 200);
        check("b2b_rd_rdata", rd, 8'h5A);

        // Reset during SHIFT period 20 of a read
        send(0, 1'b0, 32'h0000_0010, 8'h00);
        req_valid[0] = 1'b0;
        repeat (79) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("midrst_cs", cs[0], 1'b1);
        check("midrst_sclk", sclk[0], 1'b0);
        check("midrst_mosi", mosi[0], 1'b0);
        check("midrst_busy", busy[0], 1'b0);
        check("midrst_rspv", rspv[0], 1'b0);
        pulses = 0;
        repeat (300) begin
            @(posedge clk);
            #1;
            if (rspv[0]) pulses++;
        end
        check("midrst_no_rsp", pulses, 0);
        send(0, 1'b0, 32'h0000_0010, 8'h00);
        req_valid[0] = 1'b0;
        wait_rsp(0, rsp_at, rise1, per, rd);
        check("midrst_rd_rsp_cycle", rsp_at, 200);
        check("midrst_rd_rdata", rd, 8'hA5);

        // DIV=1 instance: write 0xFFFF_FFFF <- 0x3C, then read it back
        send(1, 1'b1, 32'hFFFF_FFFF, 8'h3C);
        req_valid[1] = 1'b0;
        wait_rsp(1, rsp_at, rise1, per, rd);
        check("d1_wr_rsp_cycle", rsp_at, 100);
        check("d1_first_rise", rise1, 1);
        check("d1_sclk_period", per, 2);
        check("d1_wr_frame", u[1].cap, {32'hFFFF_FFFF, 8'h02, 8'h3C, 1'b0});
        send(1, 1'b0, 32'hFFFF_FFFF, 8'h00);
        req_valid[1] = 1'b0;
        wait_rsp(1, rsp_at, rise1, per, rd);
        check("d1_rd_rsp_cycle", rsp_at, 100);
        check("d1_rd_rdata", rd, 8'h3C);

        // Request inputs change right after accept; frame keeps captured values
        send(0, 1'b1, 32'h0000_0040, 8'h77);
        req_valid[0] = 1'b0;
        req_write = 1'b0; req_adr = 32'hFFFF_FFBF; req_wdata = 8'h88;
        wait_rsp(0, rsp_at, rise1, per, rd);
        check("cap_wr_frame", u[0].cap, {32'h0000_0040, 8'h02, 8'h77, 1'b0});
        send(0, 1'b0, 32'h0000_0040, 8'h00);
        req_valid[0] = 1'b0;
        req_write = 1'b1; req_adr = 32'h0000_0010; req_wdata = 8'h11;
        wait_rsp(0, rsp_at, rise1, per, rd);
        check("cap_rd_frame", u[0].cap, {32'h0000_0040, 8'h01, 8'h00, 1'b0});
        check("cap_rd_rdata", rd, 8'h77);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/spiflash_ctrl.md
# spiflash_ctrl

Host-side sequencer for the byte-wide SPI NOR flash model used in the SD/SPI testbench. It accepts single-byte read/write requests over a valid/ready interface and generates the complete SPI frame: 32-bit address, 8-bit command, 8-bit data. It also produces the divided serial clock and chip select, and returns read data on a one-cycle response pulse. It sits between a testbench or bus-side agent and the flash device; the flash is driven with CLK_PHA = 0 and CLK_POL = 0.

## Interface
- DIV, 2: SCLK half-period in clk cycles; static, legal range ≥ 1.
- GAP, 4: minimum CS-high clk cycles between frames; static, legal range ≥ 1.
- clk  in  1  system clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high.
- ReqValid  in  1  request present.
- ReqReady  out  1  controller can accept a request.
- ReqWrite  in  1  1 = write, 0 = read.
- ReqAdr  in  32  byte address.
- ReqWData  in  8  write data; ignored for reads.
- RspValid  out  1  one-cycle pulse when the frame completes.
- RspRData  out  8  read data; 0 for writes; held until the next RspValid.
- Busy  out  1  a frame or gap is in progress.
- SCLK  out  1  serial clock; idles low.
- CS  out  1  chip select, active low; idles high.
- MOSI  out  1  serial data to the flash.
- MISO  in  1  serial data from the flash.

## Operation
- States:
  - IDLE: CS = 1, SCLK = 0.
  - SETUP: CS = 0, SCLK = 0, for DIV cycles.
  - SHIFT: 49 SCLK periods.
  - HOLD: CS = 0, SCLK = 0, for DIV cycles.
  - GAP: CS = 1, for GAP cycles.
  - Return to IDLE.
- ReqReady = (state == IDLE). On accept (ReqValid & ReqReady), ReqWrite, ReqAdr and ReqWData are captured into internal registers. Later changes on the request inputs have no effect on the frame.
- Frame, numbered by SCLK period:
  - Periods 1–32: ReqAdr[31] first, down to ReqAdr[0].
  - Periods 33–40: command, MSB first; 0x02 for write, 0x01 for read.
  - Periods 41–48: ReqWData MSB first for writes; MOSI = 0 for reads.
  - Period 49: MOSI = 0. This is the commit period the flash needs to write the array or end the read.
- MOSI is valid from SETUP entry for bit 1. It changes only on SCLK falling-edge cycles and is stable across every rising edge.
- Reads: MISO is sampled in the clk cycle where SCLK rises in periods 41–48, MSB first, into a shift register. RspRData is loaded from that register at HOLD exit.
- All 32 address bits are always sent. The flash ignores bits above its SIZE.
- SCLK never toggles while CS = 1, because the flash counter advances on SCLK regardless of CS.
- Busy = (state != IDLE).

## Timing
- Reset values, from the cycle after reset is sampled high and held while reset stays high:
  - CS = 1, SCLK = 0, MOSI = 0.
  - RspValid = 0, RspRData = 0.
  - Busy = 0, ReqReady = 0.
- ReqReady rises in the first cycle after reset deasserts.
- Call the accept edge cycle 0.
  - CS falls in cycle 1.
  - The first SCLK rise occurs DIV cycles after SETUP entry.
  - SCLK toggles every DIV cycles for 98 edges.
  - RspValid is high in cycle 100·DIV, and CS rises in that same cycle.
- ReqReady is high again in cycle 100·DIV + GAP. Back-to-back requests are therefore spaced by exactly 100·DIV + GAP cycles.
- ReqValid asserted while Busy is ignored, not queued.
- Reset mid-frame, in any state: on the next edge CS = 1, SCLK = 0, MOSI = 0 and the state is IDLE. No RspValid is produced and no GAP is enforced. The captured request is discarded.
- DIV = 1: SCLK is clk/2, a rise every other cycle. All latency formulas above still hold.

## Test plan
- DIV = 2, GAP = 4, write ReqAdr = 0x0000_0010, ReqWData = 0xA5.
  - Required MOSI bit stream: 0x00000010, then 0x02, then 0xA5, then 0.
  - Exactly 49 SCLK rises while CS = 0.
  - RspValid at cycle 200 with RspRData = 0x00.
- Read 0x10 from a flash model preloaded with 0xA5.
  - Command bits are 0x01.
  - MOSI = 0 in periods 41–49.
  - RspRData = 0xA5 with RspValid at cycle 200.
- ReqValid held high across two requests: write 0x20/0x5A, then read 0x20.
  - CS is high for exactly 4 cycles between the frames.
  - The second accept is at cycle 204.
  - The read returns 0x5A.
- Assert reset for 1 cycle during SHIFT period 20.
  - Next cycle: CS = 1, SCLK = 0, no RspValid.
  - A subsequent read 0x10 returns 0xA5 normally.
- DIV = 1, write 0xFFFF_FFFF/0x3C, then read.
  - SCLK period is 2 clk cycles.
  - RspValid at cycle 100.
  - The read returns 0x3C.
- Change ReqAdr, ReqWData and ReqWrite in the cycle after accept.
  - The frame bits match the values captured at accept.
